cache_mem_responder: RTL and testbench

//   Memory-side responder for the L1 cache miss interface. Accepts line-sized

---
 rtl/cache_mem_responder.sv | 153 +++++++++++++++
 tb/tb_cache_mem_responder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : cache_mem_responder
// Brief    : Line-granular backing store for L1 miss traffic with a fixed
//            access latency and a one-cycle mem_valid acknowledge.
//            Optional macro MEM_RANGE_CHECK_EN adds the mem_err output.
// Revision : 1.0 - initial release
// ============================================================================
module cache_mem_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int WORD_WIDTH  = 32,
    parameter int LINE_WORDS  = 8,
    parameter int DEPTH_LINES = 256,
    parameter int LATENCY     = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             mem_read,
    input  logic                             mem_write,
    input  logic [ADDR_WIDTH-1:0]            mem_addr,
    input  logic [LINE_WORDS*WORD_WIDTH-1:0] mem_wdata,
    output logic [LINE_WORDS*WORD_WIDTH-1:0] mem_rdata,
    output logic                             mem_valid,
`ifdef MEM_RANGE_CHECK_EN
    output logic                             mem_busy,
    output logic                             mem_err
`else
    output logic                             mem_busy
`endif
);

    localparam int c_LINE_BITS = LINE_WORDS * WORD_WIDTH;
    localparam int c_OFF       = $clog2(c_LINE_BITS / 8);
    localparam int c_IDX_W     = $clog2(DEPTH_LINES);
    localparam int c_CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_op_write;
    logic [c_IDX_W-1:0]     r_idx;
    logic [c_LINE_BITS-1:0] r_wdata;
    logic [c_LINE_BITS-1:0] r_rdata;
    logic [c_LINE_BITS-1:0] r_mem [DEPTH_LINES];

    logic                   w_in_idle;
    logic                   w_accept;
    logic                   w_enter_resp;
    logic                   w_cur_write;
    logic [c_IDX_W-1:0]     w_cur_idx;
    logic [c_LINE_BITS-1:0] w_cur_wdata;
    logic                   w_cur_err;
    logic                   w_mem_we;
    logic                   w_unused_addr;

    assign w_unused_addr = ^mem_addr;

    assign w_in_idle    = (r_state == ST_IDLE);
    assign w_accept     = w_in_idle && (mem_read || mem_write);
    assign w_enter_resp = (w_next_state == ST_RESP) && (r_state != ST_RESP);

    // With LATENCY=1 the store is accessed on the accept edge itself, so the
    // live request is used while idle and the latched copy afterwards.
    assign w_cur_write = w_in_idle ? mem_write : r_op_write;
    assign w_cur_idx   = w_in_idle ? mem_addr[c_OFF +: c_IDX_W] : r_idx;
    assign w_cur_wdata = w_in_idle ? mem_wdata : r_wdata;

`ifdef MEM_RANGE_CHECK_EN
    logic r_err;
    logic w_addr_oob;

    assign w_addr_oob = ((mem_addr >> (c_OFF + c_IDX_W)) != '0);
    assign w_cur_err  = w_in_idle ? w_addr_oob : r_err;
    assign mem_err    = (r_state == ST_RESP) && r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_addr_oob;
        end
    end
`else
    assign w_cur_err = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (mem_read || mem_write) begin
                    w_next_state = (LATENCY == 1) ? ST_RESP : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (r_cnt == c_CNT_W'(1)) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_op_write <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_cnt      <= c_CNT_W'(LATENCY - 1);
                r_op_write <= mem_write;
                r_idx      <= mem_addr[c_OFF +: c_IDX_W];
                r_wdata    <= mem_wdata;
            end else if (r_state == ST_BUSY) begin
                r_cnt <= r_cnt - c_CNT_W'(1);
            end
            if (w_enter_resp) begin
                if (w_cur_err) begin
                    r_rdata <= '0;
                end else if (!w_cur_write) begin
                    r_rdata <= r_mem[w_cur_idx];
                end
            end
        end
    end

    // Store is deliberately not reset; rst only blocks an in-flight commit.
    assign w_mem_we = w_enter_resp && w_cur_write && !w_cur_err && !rst;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_cur_idx] <= w_cur_wdata;
        end
    end

    assign mem_rdata = r_rdata;
    assign mem_valid = (r_state == ST_RESP);
    assign mem_busy  = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_mem_responder
// Brief    : Self-checking bench for cache_mem_responder (LATENCY=4 and
//            LATENCY=1 instances) using an expected-line scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_mem_responder;

    localparam int LAT = 4;
    typedef logic [255:0] line_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] mem_addr = '0;
    line_t       mem_wdata = '0;
    line_t       mem_rdata;
    logic        mem_valid;
    logic        mem_busy;

    logic        rd_b = 1'b0;
    logic        wr_b = 1'b0;
    logic [31:0] addr_b = '0;
    line_t       wdata_b = '0;
    line_t       rdata_b;
    logic        valid_b;
    logic        busy_b;

`ifdef MEM_RANGE_CHECK_EN
    logic        mem_err;
    logic        err_b;
`endif

    int    errors = 0;
    int    checks = 0;
    line_t exp_q[$];

    always #5 clk = ~clk;

    cache_mem_responder #(.LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_valid(mem_valid),
`ifdef MEM_RANGE_CHECK_EN
        .mem_busy(mem_busy), .mem_err(mem_err)
`else
        .mem_busy(mem_busy)
`endif
    );

    cache_mem_responder #(.LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .mem_read(rd_b), .mem_write(wr_b),
        .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_rdata(rdata_b),
        .mem_valid(valid_b),
`ifdef MEM_RANGE_CHECK_EN
        .mem_busy(busy_b), .mem_err(err_b)
`else
        .mem_busy(busy_b)
`endif
    );

    function automatic line_t pat(input logic [31:0] seed);
        line_t l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = seed + 32'(i);
        return l;
    endfunction

    // Drives one request from an idle negedge, returns at the next idle negedge.
    task automatic run_txn(input bit r, input bit w, input logic [31:0] a,
                           input line_t d, output int lat, output bit to,
                           output line_t got, output bit got_err);
        mem_read = r; mem_write = w; mem_addr = a; mem_wdata = d;
        lat = 0; to = 1'b1; got = '0; got_err = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); @(negedge clk);
            lat++;
            if (mem_valid) begin
                to  = 1'b0;
                got = mem_rdata;
`ifdef MEM_RANGE_CHECK_EN
                got_err = mem_err;
`endif
                break;
            end
        end
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", mem_valid); end
        checks++; if (mem_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", mem_busy); end
        checks++; if (mem_rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", mem_rdata); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_read();
        int lat; bit to, ge; line_t got, e;
        run_txn(1'b0, 1'b1, 32'h40, pat(32'hA000_0000), lat, to, got, ge);
        checks++; if (to || lat != LAT) begin errors++; $display("FAIL wr_latency: got %0d expected %0d", lat, LAT); end
        exp_q.push_back(pat(32'hA000_0000));
        mem_read = 1'b1; mem_addr = 32'h40;
        @(posedge clk); @(negedge clk);
        checks++; if (mem_busy !== 1'b1) begin errors++; $display("FAIL busy_after_accept: got %b expected 1", mem_busy); end
        lat = 1; to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (mem_valid) begin to = 1'b0; break; end
            @(posedge clk); @(negedge clk);
            lat++;
        end
        checks++; if (to || lat != LAT) begin errors++; $display("FAIL rd_latency: got %0d expected %0d", lat, LAT); end
        e = exp_q.pop_front();
        checks++; if (mem_rdata !== e) begin errors++; $display("FAIL rd_line2: got %h expected %h", mem_rdata, e); end
        mem_read = 1'b0;
        @(negedge clk);
        checks++; if (mem_valid !== 1'b0 || mem_busy !== 1'b0) begin errors++; $display("FAIL single_pulse: got valid=%b busy=%b expected 0/0", mem_valid, mem_busy); end
    endtask

    task automatic test_write_read();
        int lat; bit to, ge; line_t got, e;
        run_txn(1'b0, 1'b1, 32'h80, {8{32'hDEADBEEF}}, lat, to, got, ge);
        checks++; if (to) begin errors++; $display("FAIL wr80_timeout: got none expected pulse"); end
        exp_q.push_back({8{32'hDEADBEEF}});
        run_txn(1'b1, 1'b0, 32'h80, '0, lat, to, got, ge);
        e = exp_q.pop_front();
        checks++; if (to || got !== e) begin errors++; $display("FAIL rd80: got %h expected %h", got, e); end
        exp_q.push_back({8{32'hDEADBEEF}});
        run_txn(1'b1, 1'b0, 32'h9C, '0, lat, to, got, ge);
        e = exp_q.pop_front();
        checks++; if (to || got !== e) begin errors++; $display("FAIL rd9C: got %h expected %h", got, e); end
    endtask

    task automatic test_drop();
        int lat; bit to; line_t e;
        exp_q.push_back({8{32'hDEADBEEF}});
        mem_read = 1'b1; mem_addr = 32'h80;
        @(posedge clk); @(negedge clk);
        mem_read = 1'b0; mem_addr = 32'h40;
        lat = 1; to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (mem_valid) begin to = 1'b0; break; end
            @(posedge clk); @(negedge clk);
            lat++;
        end
        checks++; if (to || lat != LAT) begin errors++; $display("FAIL drop_latency: got %0d expected %0d", lat, LAT); end
        e = exp_q.pop_front();
        checks++; if (mem_rdata !== e) begin errors++; $display("FAIL drop_rdata: got %h expected %h", mem_rdata, e); end
        @(negedge clk);
    endtask

    task automatic test_both();
        int c1, c2; bit to; line_t e;
        exp_q.push_back({8{32'hDEADBEEF}});
        exp_q.push_back(pat(32'h3300_0000));
        mem_read = 1'b1; mem_write = 1'b1; mem_addr = 32'h100; mem_wdata = pat(32'h3300_0000);
        c1 = 0; to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); @(negedge clk);
            c1++;
            if (mem_valid) begin to = 1'b0; break; end
        end
        mem_write = 1'b0;
        e = exp_q.pop_front();
        checks++; if (to || c1 != LAT || mem_rdata !== e) begin errors++; $display("FAIL both_first: lat %0d rdata %h expected lat %0d rdata %h", c1, mem_rdata, LAT, e); end
        c2 = 0; to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); @(negedge clk);
            c2++;
            if (mem_valid) begin to = 1'b0; break; end
        end
        checks++; if (to || c2 < LAT + 1) begin errors++; $display("FAIL both_gap: got %0d expected >= %0d", c2, LAT + 1); end
        e = exp_q.pop_front();
        checks++; if (mem_rdata !== e) begin errors++; $display("FAIL both_fill: got %h expected %h", mem_rdata, e); end
        mem_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int lat; bit to, ge, seen; line_t got, e;
        mem_write = 1'b1; mem_addr = 32'h40; mem_wdata = pat(32'h4400_0000);
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        rst = 1'b1; mem_write = 1'b0;
        #1;
        checks++; if (mem_valid !== 1'b0 || mem_busy !== 1'b0 || mem_rdata !== '0) begin errors++; $display("FAIL abort_reset_state: got valid=%b busy=%b rdata=%h expected 0", mem_valid, mem_busy, mem_rdata); end
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mem_valid) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL abort_pulse: got pulse expected none"); end
        exp_q.push_back(pat(32'hA000_0000));
        run_txn(1'b1, 1'b0, 32'h40, '0, lat, to, got, ge);
        e = exp_q.pop_front();
        checks++; if (to || got !== e) begin errors++; $display("FAIL abort_preserve: got %h expected %h", got, e); end
    endtask

    task automatic test_latency1();
        bit v[16];
        bit consec;
        bit gap_bad;
        int pulses, last;
        rd_b = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); @(negedge clk);
            v[i] = valid_b;
        end
        rd_b = 1'b0;
        consec = 1'b0; gap_bad = 1'b0; pulses = 0; last = -1;
        for (int i = 0; i < 16; i++) begin
            if (i > 0 && v[i] && v[i-1]) consec = 1'b1;
            if (v[i]) begin
                pulses++;
                if (last >= 0 && (i - last < 2 || i - last > 3)) gap_bad = 1'b1;
                last = i;
            end
        end
        checks++; if (!v[0]) begin errors++; $display("FAIL l1_first: got 0 expected 1"); end
        checks++; if (consec) begin errors++; $display("FAIL l1_consecutive: got adjacent pulses expected none"); end
        checks++; if (pulses < 5 || gap_bad) begin errors++; $display("FAIL l1_spacing: got %0d pulses gap_bad=%b expected >=5 and spacing 2..3", pulses, gap_bad); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_range();
        int lat; bit to, ge; line_t got, e;
        run_txn(1'b0, 1'b1, 32'h0, pat(32'h6600_0000), lat, to, got, ge);
        run_txn(1'b0, 1'b1, 32'h0001_0000, pat(32'h7700_0000), lat, to, got, ge);
        checks++; if (to || lat != LAT) begin errors++; $display("FAIL range_wr_latency: got %0d expected %0d", lat, LAT); end
`ifdef MEM_RANGE_CHECK_EN
        checks++; if (ge !== 1'b1) begin errors++; $display("FAIL range_err: got %b expected 1", ge); end
        exp_q.push_back(pat(32'h6600_0000));
`else
        exp_q.push_back(pat(32'h7700_0000));
`endif
        run_txn(1'b1, 1'b0, 32'h0, '0, lat, to, got, ge);
        e = exp_q.pop_front();
        checks++; if (to || got !== e) begin errors++; $display("FAIL range_line0: got %h expected %h", got, e); end
`ifdef MEM_RANGE_CHECK_EN
        checks++; if (ge !== 1'b0) begin errors++; $display("FAIL range_err_clear: got %b expected 0", ge); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_write_read();
        test_drop();
        test_both();
        test_reset_abort();
        test_latency1();
        test_range();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
